// File: rtl/hm_irq.sv
// Hardware-monitor status/interrupt collector: W1C pending flags, interrupt mask,
// BAR-number FIFO and link-transition counter behind the CSR bus.
module hm_irq #(
  parameter logic [3:0] CSR_ADDR        = 4'h0,
  parameter int         FIFO_DEPTH_LOG2 = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  input  logic        ev_rx_timeout,
  input  logic        ev_tx_timeout,
  input  logic        ev_wr_timeout,
  input  logic        ev_hm_end,
  input  logic        ev_write_bar,
  input  logic        ev_read_exp,
  input  logic        lnk_up_n,
  input  logic [4:0]  write_bar_number
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  logic [7:0]    status_q, status_d;
  logic [7:0]    mask_q, mask_d;
  logic [31:0]   csr_do_q, csr_do_d;
  logic          irq_q, irq_d;
  logic          lnk_r_q, lnk_r_d;
  logic [15:0]   lnk_cnt_q, lnk_cnt_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    fifo_q [DEPTH];

  logic          sel;
  logic [2:0]    idx;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          do_push, do_pop, overflow, link_edge;
  logic [7:0]    set_vec, w1c_vec;
  logic [4:0]    head;
  logic          unused_bits;

  assign unused_bits = ^{csr_a[9:3], csr_di[31:8]};

  assign sel   = (csr_a[13:10] == CSR_ADDR);
  assign idx   = csr_a[2:0];
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = empty ? 5'd0 : fifo_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];

  // A pop frees a slot in the same cycle, so a push onto a full FIFO only overflows without one.
  always_comb begin
    do_pop    = sel && csr_we && (idx == 3'd3) && !empty;
    do_push   = ev_write_bar && (!full || do_pop);
    overflow  = ev_write_bar && full && !do_pop;
    link_edge = (lnk_r_q != lnk_up_n);
    set_vec   = {overflow, link_edge, ev_read_exp, ev_write_bar,
                 ev_hm_end, ev_wr_timeout, ev_tx_timeout, ev_rx_timeout};
    w1c_vec   = (sel && csr_we && (idx == 3'd0)) ? csr_di[7:0] : 8'd0;
  end

  always_comb begin
    status_d  = (status_q & ~w1c_vec) | set_vec;
    mask_d    = mask_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    lnk_r_d   = lnk_up_n;
    lnk_cnt_d = lnk_cnt_q;
    irq_d     = |(status_q & mask_q);
    csr_do_d  = 32'd0;
    if (sel && csr_we && (idx == 3'd1)) mask_d = csr_di[7:0];
    if (do_push) wr_ptr_d = wr_ptr_q + CW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + CW'(1);
    if (link_edge && (lnk_cnt_q != 16'hFFFF)) lnk_cnt_d = lnk_cnt_q + 16'd1;
    if (sel) begin
      case (idx)
        3'd0: csr_do_d[7:0] = status_q;
        3'd1: csr_do_d[7:0] = mask_q;
        3'd2: begin
          csr_do_d[4:0]     = head;
          csr_do_d[16 +: CW] = count;
          csr_do_d[31]      = empty;
        end
        3'd4: begin
          csr_do_d[0]     = lnk_r_q;
          csr_do_d[31:16] = lnk_cnt_q;
        end
        default: csr_do_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      status_q  <= 8'd0;
      mask_q    <= 8'd0;
      csr_do_q  <= 32'd0;
      irq_q     <= 1'b0;
      lnk_r_q   <= 1'b1;
      lnk_cnt_q <= 16'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      status_q  <= status_d;
      mask_q    <= mask_d;
      csr_do_q  <= csr_do_d;
      irq_q     <= irq_d;
      lnk_r_q   <= lnk_r_d;
      lnk_cnt_q <= lnk_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge sys_clk) begin
    if (do_push) fifo_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= write_bar_number;
  end

  assign csr_do = csr_do_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_hm_irq.sv
// Directed testbench for hm_irq: stimulus queues expected read data / irq levels,
// a separate monitor pops and compares them as the DUT presents them.
module tb_hm_irq;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic        ev_rx_timeout, ev_tx_timeout, ev_wr_timeout;
  logic        ev_hm_end, ev_write_bar, ev_read_exp;
  logic        lnk_up_n;
  logic [4:0]  write_bar_number;

  typedef struct {
    string       name;
    logic [31:0] val;
  } expT;

  expT  expRd[$];
  expT  expIrq[$];
  logic rdStrobe  = 1'b0;
  logic rdValidQ  = 1'b0;
  logic irqStrobe = 1'b0;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  hm_irq #(.CSR_ADDR(4'h0), .FIFO_DEPTH_LOG2(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do), .irq(irq),
    .ev_rx_timeout(ev_rx_timeout), .ev_tx_timeout(ev_tx_timeout),
    .ev_wr_timeout(ev_wr_timeout), .ev_hm_end(ev_hm_end),
    .ev_write_bar(ev_write_bar), .ev_read_exp(ev_read_exp),
    .lnk_up_n(lnk_up_n), .write_bar_number(write_bar_number)
  );

  // Read data lands one edge after the address, so the valid flag is delayed to match.
  always @(posedge sys_clk) rdValidQ <= rdStrobe;

  always @(negedge sys_clk) begin
    expT item;
    if (rdValidQ) begin
      vectors++;
      if (expRd.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_read: csr_do=%h, no expected value queued", csr_do);
      end else begin
        item = expRd.pop_front();
        if (csr_do !== item.val) begin
          miscompares++;
          $display("[TB] FAIL %s: csr_do=%h, expected %h", item.name, csr_do, item.val);
        end
      end
    end
    if (irqStrobe) begin
      vectors++;
      if (expIrq.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_irq_check: irq=%b, no expected value queued", irq);
      end else begin
        item = expIrq.pop_front();
        if (irq !== item.val[0]) begin
          miscompares++;
          $display("[TB] FAIL %s: irq=%b, expected %b", item.name, irq, item.val[0]);
        end
      end
    end
  end

  // One clock cycle; all single-cycle strobes drop right after the edge.
  task automatic cyc();
    @(posedge sys_clk);
    #1;
    csr_we        = 1'b0;
    rdStrobe      = 1'b0;
    irqStrobe     = 1'b0;
    ev_rx_timeout = 1'b0;
    ev_tx_timeout = 1'b0;
    ev_wr_timeout = 1'b0;
    ev_hm_end     = 1'b0;
    ev_write_bar  = 1'b0;
    ev_read_exp   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] idx, input logic [31:0] data);
    csr_a  = {4'h0, 7'd0, idx};
    csr_di = data;
    csr_we = 1'b1;
    cyc();
  endtask

  task automatic checkOutput(input logic [13:0] addr, input logic [31:0] val, input string name);
    expT item;
    item.name = name;
    item.val  = val;
    expRd.push_back(item);
    csr_a    = addr;
    rdStrobe = 1'b1;
    cyc();
  endtask

  task automatic readReg(input logic [2:0] idx, input logic [31:0] val, input string name);
    checkOutput({4'h0, 7'd0, idx}, val, name);
  endtask

  task automatic checkIrq(input logic val, input string name);
    expT item;
    item.name = name;
    item.val  = {31'd0, val};
    expIrq.push_back(item);
    irqStrobe = 1'b1;
    cyc();
  endtask

  task automatic pushBar(input logic [4:0] num);
    ev_write_bar     = 1'b1;
    write_bar_number = num;
    cyc();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    csr_a = '0; csr_we = 1'b0; csr_di = '0;
    ev_rx_timeout = 1'b0; ev_tx_timeout = 1'b0; ev_wr_timeout = 1'b0;
    ev_hm_end = 1'b0; ev_write_bar = 1'b0; ev_read_exp = 1'b0;
    lnk_up_n = 1'b1; write_bar_number = '0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    checkIrq(1'b0, "reset_irq");
    readReg(3'd0, 32'h0000_0000, "reset_status");
    readReg(3'd1, 32'h0000_0000, "reset_mask");
    readReg(3'd2, 32'h8000_0000, "reset_fifo");
    readReg(3'd4, 32'h0000_0001, "reset_link");

    // Mask readback, unselected bank and unused index.
    applyStimulus(3'd1, 32'hFFFF_FF5A);
    readReg(3'd1, 32'h0000_005A, "mask_rw");
    checkOutput({4'h1, 7'd0, 3'd1}, 32'h0, "unselected_bank");
    readReg(3'd5, 32'h0, "unused_index");
    csr_a = {4'h1, 7'd0, 3'd1}; csr_di = 32'h0; csr_we = 1'b1; cyc();
    readReg(3'd1, 32'h0000_005A, "foreign_bank_write");

    // Masked-in event raises irq two edges later; W1C drops it two edges after the write.
    applyStimulus(3'd1, 32'h08);
    ev_hm_end = 1'b1; cyc();
    readReg(3'd0, 32'h08, "hm_end_status");
    checkIrq(1'b1, "hm_end_irq");
    applyStimulus(3'd0, 32'h08);
    checkIrq(1'b1, "w1c_irq_lag");
    checkIrq(1'b0, "w1c_irq_clear");
    readReg(3'd0, 32'h00, "w1c_status");
    applyStimulus(3'd1, 32'h00);
    ev_hm_end = 1'b1; cyc();
    checkIrq(1'b0, "masked_irq_a");
    checkIrq(1'b0, "masked_irq_b");
    checkIrq(1'b0, "masked_irq_c");
    readReg(3'd0, 32'h08, "masked_status");
    applyStimulus(3'd0, 32'hFF);

    // Five pushes into a depth-4 FIFO: last one overflows.
    for (int i = 1; i <= 5; i++) pushBar(5'(i));
    readReg(3'd0, 32'h90, "overflow_status");
    readReg(3'd2, 32'h0004_0001, "fifo_full");
    applyStimulus(3'd3, 32'h0);
    readReg(3'd2, 32'h0003_0002, "pop1");
    applyStimulus(3'd3, 32'h0);
    readReg(3'd2, 32'h0002_0003, "pop2");
    applyStimulus(3'd3, 32'h0);
    readReg(3'd2, 32'h0001_0004, "pop3");
    applyStimulus(3'd3, 32'h0);
    readReg(3'd2, 32'h8000_0000, "pop4_empty");
    applyStimulus(3'd3, 32'h0);
    readReg(3'd2, 32'h8000_0000, "pop_empty_ignored");
    applyStimulus(3'd0, 32'hFF);

    // Push and pop together on a full FIFO.
    for (int i = 1; i <= 4; i++) pushBar(5'(i));
    ev_write_bar = 1'b1; write_bar_number = 5'd7;
    applyStimulus(3'd3, 32'h0);
    readReg(3'd2, 32'h0004_0002, "full_push_pop");
    readReg(3'd0, 32'h10, "full_push_pop_no_ovf");
    for (int i = 0; i < 3; i++) applyStimulus(3'd3, 32'h0);
    readReg(3'd2, 32'h0001_0007, "full_push_pop_tail");
    applyStimulus(3'd3, 32'h0);

    // Push and pop together on an empty FIFO.
    ev_write_bar = 1'b1; write_bar_number = 5'd9;
    applyStimulus(3'd3, 32'h0);
    readReg(3'd2, 32'h0001_0009, "empty_push_pop");
    applyStimulus(3'd3, 32'h0);
    applyStimulus(3'd0, 32'hFF);

    // Asynchronous reset in the middle of a cycle wipes flags, mask and FIFO.
    applyStimulus(3'd1, 32'hFF);
    ev_write_bar = 1'b1; write_bar_number = 5'd10; ev_rx_timeout = 1'b1; cyc();
    cyc();
    checkIrq(1'b1, "pre_reset_irq");
    sys_rst_n = 1'b0;
    #2 sys_rst_n = 1'b1;
    checkIrq(1'b0, "midreset_irq");
    readReg(3'd2, 32'h8000_0000, "midreset_fifo");
    readReg(3'd0, 32'h0, "midreset_status");
    readReg(3'd1, 32'h0, "midreset_mask");

    // Link tracking and counter saturation.
    lnk_up_n = 1'b0; cyc();
    lnk_up_n = 1'b1; cyc();
    readReg(3'd0, 32'h40, "link_flag");
    readReg(3'd4, 32'h0002_0001, "link_count2");
    for (int i = 0; i < 65537; i++) begin
      lnk_up_n = ~lnk_up_n;
      cyc();
    end
    cyc();
    readReg(3'd4, 32'hFFFF_0000, "link_saturated");
    applyStimulus(3'd0, 32'hFF);
    lnk_up_n = 1'b1; cyc();
    readReg(3'd0, 32'h40, "sat_edge_flag");
    readReg(3'd4, 32'hFFFF_0001, "sat_edge_hold");

    // Set beats W1C in the same cycle.
    applyStimulus(3'd0, 32'hFF);
    ev_rx_timeout = 1'b1;
    applyStimulus(3'd0, 32'h01);
    readReg(3'd0, 32'h01, "set_wins_w1c");

    for (int i = 0; i < 10 && (expRd.size() != 0 || expIrq.size() != 0); i++) cyc();
    if (expRd.size() != 0 || expIrq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d reads and %0d irq checks left, expected 0",
               expRd.size(), expIrq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
